snake_dir_ctrl: RTL and testbench

// - Snake-game steering controller: debounces four active-low direction keys, queues accepted turns,
//   and commits one turn per game-step tick, so fast key combos are not lost between steps.
// - Rejects 180-degree reversals and repeats.
// - Sits between the board keys and the snake movement/VGA logic; outputs the current heading code.

---
 rtl/snake_pkg.sv | 32 +++
 rtl/key_debounce.sv | 54 +++++
 rtl/snake_dir_ctrl.sv | 131 +++++++++++++
 tb/tb_snake_dir_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared heading definitions for the snake steering, movement and VGA logic.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   dir_e     - 3-bit heading code, STOP/UP/DOWN/LEFT/RIGHT
//   opposite  - heading that would be a 180-degree reversal of the given one
package snake_pkg;

    typedef enum logic [2:0] {
        DIR_STOP  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    // STOP (and any unused code) has no opposite; STOP is returned so it never
    // matches a real heading.
    function automatic logic [2:0] opposite(input logic [2:0] dir);
        logic [2:0] res;
        case (dir)
            DIR_UP:    res = DIR_DOWN;
            DIR_DOWN:  res = DIR_UP;
            DIR_LEFT:  res = DIR_RIGHT;
            DIR_RIGHT: res = DIR_LEFT;
            default:   res = DIR_STOP;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces one active-low key and emits a one-cycle pulse on each debounced press.
// Latency: raw edge to press pulse is 2 + DEB_CYCLES cycles (2-flop sync + stability count).
// Backpressure: none; the press pulse is a fire-and-forget event.
//
// Ports:
//   VGA_CLK  - clock
//   reset    - asynchronous, active-high; returns to the released (stable=1) state
//   key_n    - raw key level, active-low
//   stable   - debounced key level
//   press    - one-cycle pulse on debounced 1->0 (release produces nothing)
module key_debounce #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic VGA_CLK,
    input  logic reset,
    input  logic key_n,
    output logic stable,
    output logic press
);

    localparam int CNTW = $clog2(DEB_CYCLES + 1);

    logic            sync1;
    logic            sync2;
    logic [CNTW-1:0] cnt;

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != stable) begin
                // This cycle is the DEB_CYCLES-th consecutive mismatch: adopt the new level.
                if (cnt == CNTW'(DEB_CYCLES - 1)) begin
                    stable <= sync2;
                    cnt    <= '0;
                    // Old level 1 flipping to 0 is a press; 0->1 is a release.
                    press  <= stable;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake steering: debounces four keys, queues legal turns, commits one turn per game tick.
// Latency: raw key edge to queue push 3 + DEB_CYCLES cycles; tick to new direction 1 cycle.
// Backpressure: none upstream; presses that cannot be queued are dropped with a drop pulse.
//
// Ports:
//   VGA_CLK    - clock for all logic
//   reset      - asynchronous, active-high
//   key_n      - raw active-low keys, [0]=UP [1]=DOWN [2]=LEFT [3]=RIGHT
//   tick       - one-cycle game-step pulse; pops one queued turn into direction
//   clear      - synchronous restart: direction to STOP, queue flushed
//   direction  - committed heading (0=STOP 1=UP 2=DOWN 3=LEFT 4=RIGHT)
//   dir_change - one-cycle pulse when direction is updated from the queue
//   drop       - one-cycle pulse when a press is rejected (repeat, reversal, full queue)
//   q_count    - current queue occupancy, 0..QDEPTH
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int DEB_CYCLES    = 250000,
    parameter int QDEPTH        = 4,
    parameter int ALLOW_REVERSE = 0
) (
    input  logic                     VGA_CLK,
    input  logic                     reset,
    input  logic [3:0]               key_n,
    input  logic                     tick,
    input  logic                     clear,
    output logic [2:0]               direction,
    output logic                     dir_change,
    output logic                     drop,
    output logic [$clog2(QDEPTH):0]  q_count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [3:0]    key_stable;
    logic [3:0]    press;
    logic [3:0]    req;
    logic [2:0]    p_dir;
    logic          p_vld;
    logic [2:0]    q_mem [QDEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] tail_ptr;
    logic [2:0]    ref_dir;
    logic          q_empty;
    logic          q_full;
    logic          pop;
    logic          is_rev;
    logic          reject;
    logic          push;

    for (genvar i = 0; i < 4; i++) begin : g_deb
        key_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .VGA_CLK (VGA_CLK),
            .reset   (reset),
            .key_n   (key_n[i]),
            .stable  (key_stable[i]),
            .press   (press[i])
        );
    end

    // A press is only honoured while its key is still debounced-low.
    assign req = press & ~key_stable;

    // Lowest index wins: later assignments override earlier ones.
    always_comb begin
        p_dir = DIR_STOP;
        if (req[3]) p_dir = DIR_RIGHT;
        if (req[2]) p_dir = DIR_LEFT;
        if (req[1]) p_dir = DIR_DOWN;
        if (req[0]) p_dir = DIR_UP;
    end

    assign p_vld    = (req != 4'b0000);
    assign q_empty  = (q_count == '0);
    assign q_full   = (q_count == CW'(QDEPTH));
    assign tail_ptr = wr_ptr - PW'(1);

    // New turns are judged against where the snake will be heading once the
    // queue drains, i.e. the newest queued entry, not the current direction.
    assign ref_dir = q_empty ? direction : q_mem[tail_ptr];
    assign pop     = tick && !q_empty;
    assign is_rev  = (ALLOW_REVERSE == 0) && (ref_dir != DIR_STOP)
                     && (p_dir == opposite(ref_dir));
    // A full queue still accepts when a pop frees a slot in the same cycle.
    assign reject  = p_vld && ((p_dir == ref_dir) || is_rev || (q_full && !pop));
    assign push    = p_vld && !reject && !clear;

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            q_count    <= '0;
            direction  <= DIR_STOP;
            dir_change <= 1'b0;
            drop       <= 1'b0;
        end else if (clear) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            q_count    <= '0;
            direction  <= DIR_STOP;
            dir_change <= 1'b0;
            drop       <= 1'b0;
        end else begin
            dir_change <= pop;
            drop       <= reject;
            if (pop) begin
                direction <= q_mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // Occupancy never exceeds QDEPTH: a push to a full queue needs a pop.
            q_count <= q_count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    // The head is read before this write lands, so a pushed entry is never
    // popped in the same cycle.
    always_ff @(posedge VGA_CLK) begin
        if (push) begin
            q_mem[wr_ptr] <= p_dir;
        end
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Self-checking bench for snake_dir_ctrl with a behavioural reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_snake_dir_ctrl;

    localparam int DEB = 4;
    localparam int QD  = 4;
    localparam int HL  = DEB + 2;

    logic       VGA_CLK;
    logic       reset;
    logic [3:0] key_n;
    logic       tick;
    logic       clear;
    logic [2:0] direction;
    logic       dir_change;
    logic       drop;
    logic [2:0] q_count;

    snake_dir_ctrl #(
        .DEB_CYCLES    (DEB),
        .QDEPTH        (QD),
        .ALLOW_REVERSE (0)
    ) dut (
        .VGA_CLK    (VGA_CLK),
        .reset      (reset),
        .key_n      (key_n),
        .tick       (tick),
        .clear      (clear),
        .direction  (direction),
        .dir_change (dir_change),
        .drop       (drop),
        .q_count    (q_count)
    );

    initial VGA_CLK = 1'b0;
    always #5 VGA_CLK = ~VGA_CLK;

    int n_chk = 0;
    int n_bad = 0;
    int seg_dc = 0;
    int seg_drop = 0;

    // Reference model state
    bit         m_hist [4][HL];   // raw key samples, index HL-1 newest
    bit   [3:0] m_stable;
    bit   [3:0] m_press_prev;     // press events to be judged at the next edge
    logic [2:0] m_q[$];
    logic [2:0] m_dir;
    bit         m_dc;
    bit         m_drop;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < HL; j++) m_hist[i][j] = 1'b1;
        m_stable     = 4'hF;
        m_press_prev = 4'h0;
        m_q.delete();
        m_dir  = 3'd0;
        m_dc   = 1'b0;
        m_drop = 1'b0;
    endtask

    // One clock edge of the spec-level behaviour.
    task automatic model_step();
        logic [2:0] p;
        logic [2:0] refd;
        bit         pop;
        bit         rej;
        bit   [3:0] new_press;
        bit         all_diff;
        p = 3'd0;
        for (int i = 3; i >= 0; i--) if (m_press_prev[i]) p = 3'(i + 1);
        m_dc   = 1'b0;
        m_drop = 1'b0;
        rej    = 1'b0;
        if (clear) begin
            m_q.delete();
            m_dir = 3'd0;
        end else begin
            pop  = tick && (m_q.size() > 0);
            refd = (m_q.size() > 0) ? m_q[$] : m_dir;
            if (p != 0) begin
                // Opposite pairs are 1+2=3 and 3+4=7.
                rej = (p == refd)
                      || (refd != 0 && ((int'(p) + int'(refd) == 3) || (int'(p) + int'(refd) == 7)))
                      || (m_q.size() == QD && !pop);
                m_drop = rej;
            end
            if (pop) begin
                m_dir = m_q.pop_front();
                m_dc  = 1'b1;
            end
            if (p != 0 && !rej) m_q.push_back(p);
        end
        // Debounce: flip when the DEB synchronised samples (2 edges old and
        // older) all differ from the stable level.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < HL - 1; j++) m_hist[i][j] = m_hist[i][j+1];
            m_hist[i][HL-1] = key_n[i];
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) if (m_hist[i][j] == m_stable[i]) all_diff = 1'b0;
            new_press[i] = all_diff && m_stable[i];
            if (all_diff) m_stable[i] = ~m_stable[i];
        end
        m_press_prev = new_press;
    endtask

    task automatic run_cycle(input logic [3:0] k, input logic t, input logic c);
        key_n = k;
        tick  = t;
        clear = c;
        @(posedge VGA_CLK);
        model_step();
        @(negedge VGA_CLK);
        check_eq("direction", direction, m_dir);
        check_eq("dir_change", dir_change, m_dc);
        check_eq("drop", drop, m_drop);
        check_eq("q_count", q_count, m_q.size());
        if (dir_change) seg_dc++;
        if (drop) seg_drop++;
    endtask

    // Press the keys in mask_n (active-low) long enough to debounce, then release.
    task automatic tap(input logic [3:0] mask_n, input bit tick_on_press, input bit clear_on_press);
        bit fire;
        for (int i = 0; i < 10; i++) begin
            fire = (m_press_prev != 4'h0);
            run_cycle(mask_n, tick_on_press && fire, clear_on_press && fire);
        end
        for (int i = 0; i < 10; i++) run_cycle(4'hF, 1'b0, 1'b0);
    endtask

    task automatic seg_reset();
        seg_dc   = 0;
        seg_drop = 0;
    endtask

    initial begin
        int lat;
        logic [3:0] cur_keys;
        reset = 1'b1;
        key_n = 4'hF;
        tick  = 1'b0;
        clear = 1'b0;
        model_reset();
        repeat (3) @(negedge VGA_CLK);
        check_eq("rst_direction", direction, 0);
        check_eq("rst_dir_change", dir_change, 0);
        check_eq("rst_drop", drop, 0);
        check_eq("rst_q_count", q_count, 0);
        reset = 1'b0;
        run_cycle(4'hF, 1'b0, 1'b0);

        // Bounce on UP, then hold low: one press only.
        seg_reset();
        for (int i = 0; i < 12; i++) run_cycle(((i / 2) % 2 == 0) ? 4'b1110 : 4'b1111, 1'b0, 1'b0);
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            run_cycle(4'b1110, 1'b0, 1'b0);
            if (lat < 0 && q_count == 3'd1) lat = i;
        end
        check_eq("bounce_latency", lat, 6);
        for (int i = 0; i < 10; i++) run_cycle(4'hF, 1'b0, 1'b0);
        check_eq("bounce_qcount", q_count, 1);
        check_eq("bounce_nodrop", seg_drop, 0);
        run_cycle(4'hF, 1'b1, 1'b0);
        check_eq("bounce_tick_dir", direction, 1);
        check_eq("bounce_tick_dc", dir_change, 1);
        run_cycle(4'hF, 1'b0, 1'b0);

        // Queue order from STOP: LEFT, UP, RIGHT.
        run_cycle(4'hF, 1'b0, 1'b1);
        tap(4'b1011, 1'b0, 1'b0);
        tap(4'b1110, 1'b0, 1'b0);
        tap(4'b0111, 1'b0, 1'b0);
        check_eq("order_qcount", q_count, 3);
        seg_reset();
        run_cycle(4'hF, 1'b1, 1'b0);
        check_eq("order_dir0", direction, 3);
        run_cycle(4'hF, 1'b1, 1'b0);
        check_eq("order_dir1", direction, 1);
        run_cycle(4'hF, 1'b1, 1'b0);
        check_eq("order_dir2", direction, 4);
        run_cycle(4'hF, 1'b0, 1'b0);
        check_eq("order_dc_count", seg_dc, 3);

        // Reverse / repeat with direction UP and an empty queue.
        run_cycle(4'hF, 1'b0, 1'b1);
        tap(4'b1110, 1'b0, 1'b0);
        run_cycle(4'hF, 1'b1, 1'b0);
        check_eq("rev_setup_dir", direction, 1);
        seg_reset();
        tap(4'b1101, 1'b0, 1'b0);
        check_eq("rev_down_drop", seg_drop, 1);
        check_eq("rev_down_q", q_count, 0);
        seg_reset();
        tap(4'b1110, 1'b0, 1'b0);
        check_eq("rep_up_drop", seg_drop, 1);
        seg_reset();
        tap(4'b1011, 1'b0, 1'b0);
        check_eq("left_nodrop", seg_drop, 0);
        check_eq("left_q", q_count, 1);
        seg_reset();
        tap(4'b0111, 1'b0, 1'b0);
        check_eq("rev_right_drop", seg_drop, 1);
        check_eq("rev_right_q", q_count, 1);

        // Fill to four: queue LEFT, DOWN, RIGHT, UP.
        tap(4'b1101, 1'b0, 1'b0);
        tap(4'b0111, 1'b0, 1'b0);
        tap(4'b1110, 1'b0, 1'b0);
        check_eq("full_q", q_count, 4);
        seg_reset();
        tap(4'b1011, 1'b1, 1'b0);
        check_eq("full_tick_q", q_count, 4);
        check_eq("full_tick_nodrop", seg_drop, 0);
        check_eq("full_tick_dir", direction, 3);
        check_eq("full_tick_dc", seg_dc, 1);
        seg_reset();
        tap(4'b1101, 1'b0, 1'b0);
        check_eq("full_notick_drop", seg_drop, 1);
        check_eq("full_notick_q", q_count, 4);

        // Simultaneous UP+DOWN: UP wins, no drop.
        run_cycle(4'hF, 1'b0, 1'b1);
        seg_reset();
        tap(4'b1100, 1'b0, 1'b0);
        check_eq("simul_q", q_count, 1);
        check_eq("simul_nodrop", seg_drop, 0);

        // clear together with tick and a press.
        tap(4'b1011, 1'b0, 1'b0);
        tap(4'b1101, 1'b0, 1'b0);
        check_eq("clr_setup_q", q_count, 3);
        seg_reset();
        tap(4'b0111, 1'b1, 1'b1);
        check_eq("clr_dir", direction, 0);
        check_eq("clr_q", q_count, 0);
        check_eq("clr_no_dc", seg_dc, 0);
        check_eq("clr_no_drop", seg_drop, 0);

        // Async reset mid-debounce with a non-empty queue.
        tap(4'b1110, 1'b0, 1'b0);
        run_cycle(4'hF, 1'b1, 1'b0);
        tap(4'b1011, 1'b0, 1'b0);
        check_eq("areset_setup_q", q_count, 1);
        check_eq("areset_setup_dir", direction, 1);
        for (int i = 0; i < 3; i++) run_cycle(4'b1101, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_eq("areset_direction", direction, 0);
        check_eq("areset_q_count", q_count, 0);
        check_eq("areset_drop", drop, 0);
        check_eq("areset_dir_change", dir_change, 0);
        model_reset();
        key_n = 4'hF;
        repeat (2) @(negedge VGA_CLK);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) run_cycle(4'hF, 1'b0, 1'b0);

        // Randomised traffic against the model.
        cur_keys = 4'hF;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0:       cur_keys = 4'hF;
                    1:       cur_keys = 4'($urandom);
                    default: cur_keys = ~(4'b0001 << $urandom_range(0, 3));
                endcase
            end
            run_cycle(cur_keys, ($urandom_range(0, 5) == 0), ($urandom_range(0, 149) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
